shared_mem_port_arbiter: RTL and testbench
==========================================

// Module: shared_mem_port_arbiter
// PURPOSE
//  Shares one main-memory port between the fetch unit (instruction reads) and the memory unit
//  (data loads/stores) of a single core. Sits between those units and the memory/cache
//  interface. Allows one transaction in flight at a time. Round-robin grant on conflict.
//  Keeps a saturating conflict counter for performance reporting.
// PARAMETERS
//  DATA_WIDTH    32  width of the data words
//  ADDRESS_BITS  20  width of the addresses
//  CNT_BITS      16  width of the conflict counter
// PORTS
//  clock           in   1             single clock, rising edge
//  reset           in   1             asynchronous, active-low reset
//  i_req_valid     in   1             fetch read request
//  i_req_addr      in   ADDRESS_BITS  fetch address
//  i_req_ready     out  1             fetch request accepted this cycle
//  i_resp_valid    out  1             one-cycle pulse: fetch data valid
//  i_resp_data     out  DATA_WIDTH    instruction word
//  d_req_valid     in   1             data request
//  d_req_write     in   1             1 = store, 0 = load
//  d_req_addr      in   ADDRESS_BITS  data address
//  d_req_wdata     in   DATA_WIDTH    store data
//  d_req_ready     out  1             data request accepted this cycle
//  d_resp_valid    out  1             one-cycle pulse: load data valid or store acknowledged
//  d_resp_data     out  DATA_WIDTH    load data; 0 for a store acknowledge
//  mem_req_valid   out  1             request to memory
//  mem_req_write   out  1             store flag to memory
//  mem_req_addr    out  ADDRESS_BITS  address to memory
//  mem_req_wdata   out  DATA_WIDTH    store data to memory
//  mem_req_ready   in   1             memory accepts the request
//  mem_resp_valid  in   1             memory response (reads and writes)
//  mem_resp_data   in   DATA_WIDTH    memory read data
//  owner           out  1             current or last grantee: 0 = fetch, 1 = data
//  conflict_count  out  CNT_BITS      cycles in which both requesters were valid in IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; owner=1; last_grant=1; conflict_count=0. All *_ready,
//   *_resp_valid and mem_req_* outputs are 0. Any outstanding transaction is dropped with no response.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if exactly one requester is valid, grant it. If both are valid, grant the requester that is
//   not last_grant, and increment conflict_count (saturates at all-ones). The grantee's *_req_ready is
//   1 in the same cycle (combinational from state, the valids and last_grant). The request fields are
//   latched. last_grant and owner are updated to the grantee. Go to ISSUE.
//   ISSUE: mem_req_valid=1 with the latched fields, held stable until mem_req_ready=1, then go to WAIT.
//   WAIT: on mem_resp_valid=1, register mem_resp_data (or 0 for a store) and go to RESP.
//   RESP: the owner's *_resp_valid=1 for exactly one cycle with the registered data. Go to IDLE.
//   No request is accepted in RESP.
//  *_req_ready is never 1 outside IDLE. A requester holds valid and fields until it sees ready.
//  mem_resp_valid is ignored outside WAIT. The memory never responds in the same cycle as mem_req_ready.
//  Minimum latency: accepted at cycle 0, mem request at cycle 1 (ready), response at cycle 2,
//   *_resp_valid at cycle 3. One transaction completes per 4 cycles at best.
//  Stall states are unbounded: ISSUE and WAIT wait indefinitely.
//  d_req_write is ignored when d_req_valid=0. The fetch path is always a read.
// STRUCTURE
//  Shared include mem_arb_defs.vh: FSM state encodings (2 bits) and the OWNER_I/OWNER_D constants.
//  Sub-module rr_arbiter2: 2-input round-robin picker (inputs: req[1:0], last; outputs: gnt[1:0],
//   conflict), purely combinational. The FSM, latches and counter live in this module.
// TESTING
//  1 Reset mid-WAIT: assert reset=0 during WAIT -> all outputs 0 on the next edge. A late
//    mem_resp_valid produces no *_resp_valid.
//  2 Single fetch: i_req_addr=0x00010, memory ready immediately, responds at +1 with 0x00500093 ->
//    i_resp_valid at cycle 3 with data 0x00500093. d_resp_valid stays 0.
//  3 Conflict after reset: both valid at cycle 0 -> fetch granted first (last_grant=1).
//    Data granted in the next IDLE. conflict_count=1, then 2 if data and fetch both still valid.
//  4 Store: d_req_write=1, addr=0x00100, wdata=0xDEADBEEF, mem_req_ready delayed 3 cycles ->
//    mem_req_* stable for 4 cycles; d_resp_valid pulse with data 0.
//  5 Saturation: CNT_BITS=4, 20 conflicting rounds -> conflict_count holds 4'hF; grants alternate I,D,I,D.
//  6 Spurious response: mem_resp_valid=1 in IDLE and ISSUE -> ignored; no resp pulse, state unchanged.

Source files
------------

// File: rtl/shared_mem_port_arbiter_pkg.sv
// ============================================================================
// Module : shared_mem_port_arbiter_pkg
// Brief  : FSM encodings and owner constants shared by the memory-port arbiter
// Rev    : 1.0
// ============================================================================
`default_nettype none

package shared_mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shared_mem_port_arbiter_rr_arbiter2.sv
// ============================================================================
// Module : rr_arbiter2
// Brief  : Combinational two-way round-robin picker (bit 0 = fetch, bit 1 = data)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
    import shared_mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       conflict
);

    always_comb begin
        conflict = req[0] & req[1];
        gnt      = req;
        // On a tie the side that did not win last time gets the port.
        if (conflict) begin
            gnt = (last == OWNER_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shared_mem_port_arbiter.sv
// ============================================================================
// Module : shared_mem_port_arbiter
// Brief  : Shares one memory port between fetch and data units, one txn in flight
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shared_mem_port_arbiter
    import shared_mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int CNT_BITS     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_req_valid,
    input  logic [ADDRESS_BITS-1:0] i_req_addr,
    output logic                    i_req_ready,
    output logic                    i_resp_valid,
    output logic [DATA_WIDTH-1:0]   i_resp_data,
    input  logic                    d_req_valid,
    input  logic                    d_req_write,
    input  logic [ADDRESS_BITS-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    output logic                    d_req_ready,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_data,
    output logic                    mem_req_valid,
    output logic                    mem_req_write,
    output logic [ADDRESS_BITS-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic                    owner,
    output logic [CNT_BITS-1:0]     conflict_count
);

    arb_state_e              state_q, state_d;
    // owner and last_grant always move together, so one flop serves both.
    logic                    owner_q, owner_d;
    logic                    write_q, write_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;

    logic [1:0] gnt;
    logic       conflict;

    rr_arbiter2 u_rr (
        .req      ({d_req_valid, i_req_valid}),
        .last     (owner_q),
        .gnt      (gnt),
        .conflict (conflict)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        i_resp_valid  = 1'b0;
        d_resp_valid  = 1'b0;
        mem_req_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    i_req_ready = gnt[0];
                    d_req_ready = gnt[1];
                    owner_d     = gnt[1];
                    write_d     = gnt[1] & d_req_write;
                    addr_d      = gnt[1] ? d_req_addr  : i_req_addr;
                    wdata_d     = gnt[1] ? d_req_wdata : '0;
                    if (conflict && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = write_q ? '0 : mem_resp_data;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                i_resp_valid = (owner_q == OWNER_I);
                d_resp_valid = (owner_q == OWNER_D);
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields only reach the memory while a request is actually presented.
    assign mem_req_write  = mem_req_valid & write_q;
    assign mem_req_addr   = mem_req_valid ? addr_q  : '0;
    assign mem_req_wdata  = mem_req_valid ? wdata_q : '0;
    assign i_resp_data    = rdata_q;
    assign d_resp_data    = rdata_q;
    assign owner          = owner_q;
    assign conflict_count = cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_D;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_port_arbiter.sv
// ============================================================================
// Module : tb_shared_mem_port_arbiter
// Brief  : Self-checking bench with a transaction-level model of the arbiter
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_shared_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 20;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_req_valid = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic          i_req_ready;
    logic          i_resp_valid;
    logic [DW-1:0] i_resp_data;
    logic          d_req_valid = 1'b0;
    logic          d_req_write = 1'b0;
    logic [AW-1:0] d_req_addr = '0;
    logic [DW-1:0] d_req_wdata = '0;
    logic          d_req_ready;
    logic          d_resp_valid;
    logic [DW-1:0] d_resp_data;
    logic          mem_req_valid;
    logic          mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_req_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;
    logic          owner;
    logic [CW-1:0] conflict_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: who won last, how many conflicts seen, and what each requester is holding.
    bit            m_last;
    int            m_cnt;
    bit            p_i, p_d, p_dw;
    logic [AW-1:0] p_iaddr, p_daddr;
    logic [DW-1:0] p_dwdata;

    shared_mem_port_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AW),
        .CNT_BITS     (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_req_valid    (i_req_valid),
        .i_req_addr     (i_req_addr),
        .i_req_ready    (i_req_ready),
        .i_resp_valid   (i_resp_valid),
        .i_resp_data    (i_resp_data),
        .d_req_valid    (d_req_valid),
        .d_req_write    (d_req_write),
        .d_req_addr     (d_req_addr),
        .d_req_wdata    (d_req_wdata),
        .d_req_ready    (d_req_ready),
        .d_resp_valid   (d_resp_valid),
        .d_resp_data    (d_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .owner          (owner),
        .conflict_count (conflict_count)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_last = 1'b1;
        m_cnt  = 0;
        p_i    = 1'b0;
        p_d    = 1'b0;
        p_dw   = 1'b0;
    endtask

    task automatic drive_reqs();
        i_req_valid = p_i;
        i_req_addr  = p_iaddr;
        d_req_valid = p_d;
        d_req_write = p_d ? p_dw : 1'($urandom);
        d_req_addr  = p_daddr;
        d_req_wdata = p_dwdata;
    endtask

    // One complete transaction from IDLE back to IDLE, checked cycle by cycle.
    task automatic do_round(input int rdy_dly, input int rsp_dly,
                            input logic [DW-1:0] rdata, input bit spurious);
        bit            conf, g, w;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, erd;
        conf = p_i & p_d;
        g    = conf ? ~m_last : p_d;
        w    = g ? p_dw : 1'b0;
        ea   = g ? p_daddr : p_iaddr;
        ewd  = g ? p_dwdata : '0;
        erd  = w ? '0 : rdata;

        drive_reqs();
        mem_req_ready  = 1'b0;
        mem_resp_valid = spurious;
        @(negedge clock);
        n_assert++;
        if ({i_req_ready, d_req_ready} !== {~g, g}) begin
            n_fail++;
            $display("FAIL grant: got i/d ready %b%b, required %b%b", i_req_ready, d_req_ready, ~g, g);
        end
        n_assert++;
        if (conflict_count !== CW'(m_cnt)) begin
            n_fail++;
            $display("FAIL count_idle: got %0d, required %0d", conflict_count, m_cnt);
        end
        @(posedge clock); #1;
        m_last = g;
        if (conf && m_cnt < (1 << CW) - 1) m_cnt++;
        if (g) p_d = 1'b0; else p_i = 1'b0;
        i_req_valid = p_i;
        d_req_valid = p_d;

        for (int k = 0; k <= rdy_dly; k++) begin
            mem_req_ready  = (k == rdy_dly);
            mem_resp_valid = spurious && (k != rdy_dly);
            mem_resp_data  = DW'($urandom);
            @(negedge clock);
            n_assert++;
            if ({mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata} !== {1'b1, w, ea, ewd}) begin
                n_fail++;
                $display("FAIL mem_req: got v=%b w=%b a=%h d=%h, required v=1 w=%b a=%h d=%h",
                         mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, w, ea, ewd);
            end
            n_assert++;
            if ({owner, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, conflict_count}
                !== {g, 4'b0000, CW'(m_cnt)}) begin
                n_fail++;
                $display("FAIL issue_side: got owner=%b rdy=%b%b resp=%b%b cnt=%0d, required owner=%b rdy=00 resp=00 cnt=%0d",
                         owner, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, conflict_count, g, m_cnt);
            end
            @(posedge clock); #1;
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        for (int k = 0; k <= rsp_dly; k++) begin
            mem_resp_valid = (k == rsp_dly);
            mem_resp_data  = (k == rsp_dly) ? rdata : DW'($urandom);
            @(negedge clock);
            n_assert++;
            if ({mem_req_valid, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid} !== 5'b0) begin
                n_fail++;
                $display("FAIL wait_quiet: got memv=%b rdy=%b%b resp=%b%b, required all 0",
                         mem_req_valid, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid);
            end
            @(posedge clock); #1;
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = DW'($urandom);

        @(negedge clock);
        n_assert++;
        if ({i_resp_valid, d_resp_valid, i_req_ready, d_req_ready} !== {~g, g, 2'b00}) begin
            n_fail++;
            $display("FAIL resp_valid: got resp=%b%b rdy=%b%b, required resp=%b%b rdy=00",
                     i_resp_valid, d_resp_valid, i_req_ready, d_req_ready, ~g, g);
        end
        n_assert++;
        if ((g ? d_resp_data : i_resp_data) !== erd) begin
            n_fail++;
            $display("FAIL resp_data: got %h, required %h", g ? d_resp_data : i_resp_data, erd);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        drive_reqs();
        repeat (2) @(negedge clock);
        n_assert++;
        if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid, mem_req_write,
             mem_req_addr, mem_req_wdata, owner, conflict_count} !== {6'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b%b resp=%b%b memv=%b owner=%b cnt=%0d, required zeros with owner=1",
                     i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid, owner, conflict_count);
        end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_conflict();
        p_i = 1'b1; p_iaddr = AW'($urandom);
        p_d = 1'b1; p_dw = 1'b0; p_daddr = AW'($urandom); p_dwdata = DW'($urandom);
        do_round(0, 0, DW'($urandom), 1'b0);
        p_i = 1'b1; p_iaddr = AW'($urandom);
        do_round(1, 0, DW'($urandom), 1'b0);
        n_assert++;
        if (conflict_count !== CW'(2)) begin
            n_fail++;
            $display("FAIL conflict_two: got %0d, required 2", conflict_count);
        end
        do_round(0, 1, DW'($urandom), 1'b0);
    endtask

    task automatic test_single_fetch();
        p_i = 1'b1; p_iaddr = 20'h00010;
        do_round(0, 0, 32'h00500093, 1'b0);
    endtask

    task automatic test_store();
        p_d = 1'b1; p_dw = 1'b1; p_daddr = 20'h00100; p_dwdata = 32'hDEADBEEF;
        do_round(3, 1, 32'h12345678, 1'b0);
    endtask

    task automatic test_spurious();
        logic [CW-1:0] cnt_before;
        bit            own_before;
        cnt_before = conflict_count;
        own_before = owner;
        p_i = 1'b0; p_d = 1'b0;
        drive_reqs();
        mem_resp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_resp_data = DW'($urandom);
            @(negedge clock);
            n_assert++;
            if ({i_resp_valid, d_resp_valid, mem_req_valid, i_req_ready, d_req_ready, owner, conflict_count}
                !== {5'b0, own_before, cnt_before}) begin
                n_fail++;
                $display("FAIL spurious_idle: got resp=%b%b memv=%b owner=%b cnt=%0d, required quiet owner=%b cnt=%0d",
                         i_resp_valid, d_resp_valid, mem_req_valid, owner, conflict_count, own_before, cnt_before);
            end
            @(posedge clock); #1;
        end
        mem_resp_valid = 1'b0;
        p_i = 1'b1; p_iaddr = AW'($urandom);
        do_round(3, 2, DW'($urandom), 1'b1);
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 20; r++) begin
            if (!p_i) begin p_i = 1'b1; p_iaddr = AW'($urandom); end
            if (!p_d) begin
                p_d = 1'b1; p_dw = 1'($urandom); p_daddr = AW'($urandom); p_dwdata = DW'($urandom);
            end
            do_round(0, 0, DW'($urandom), 1'b0);
        end
        n_assert++;
        if (conflict_count !== 4'hF) begin
            n_fail++;
            $display("FAIL saturation: got %h, required f", conflict_count);
        end
        p_i = 1'b0; p_d = 1'b0;
        drive_reqs();
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            if (!p_i && ($urandom_range(0, 1) == 1)) begin p_i = 1'b1; p_iaddr = AW'($urandom); end
            if (!p_d && ($urandom_range(0, 1) == 1)) begin
                p_d = 1'b1; p_dw = 1'($urandom); p_daddr = AW'($urandom); p_dwdata = DW'($urandom);
            end
            if (!p_i && !p_d) begin p_i = 1'b1; p_iaddr = AW'($urandom); end
            do_round($urandom_range(0, 3), $urandom_range(0, 3), DW'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_wait();
        p_i = 1'b1; p_iaddr = AW'($urandom); p_d = 1'b0;
        drive_reqs();
        @(posedge clock); #1;
        i_req_valid   = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        @(negedge clock);
        n_assert++;
        if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid, owner, conflict_count}
            !== {5'b0, 1'b1, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got rdy=%b%b resp=%b%b memv=%b owner=%b cnt=%0d, required zeros owner=1",
                     i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_req_valid, owner, conflict_count);
        end
        @(posedge clock); #1;
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hCAFEF00D;
        @(posedge clock); #1;
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_assert++;
            if ({i_resp_valid, d_resp_valid, mem_req_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL late_response: got resp=%b%b memv=%b, required 000",
                         i_resp_valid, d_resp_valid, mem_req_valid);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        p_iaddr = '0; p_daddr = '0; p_dwdata = '0;
        test_reset();
        test_conflict();
        test_single_fetch();
        test_store();
        test_spurious();
        test_saturation();
        test_random();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
